lpf_mac_sched: RTL and testbench
================================

Name: lpf_mac_sched

Overview:
- Round-robin scheduler that shares one 16-tap FIR multiply-accumulate engine (the team's low-pass coefficient set) between NCH sample channels.
- Keeps a private 16-deep sample history per channel and arbitrates channel requests.
- Sequences the shared MAC through 16 tap cycles per request, then rounds the accumulator into an 8-bit output tagged with its channel.
- Sits between the per-channel sample front-ends and the shared MAC/coefficient ROM.

Parameters:
- NCH, 4: number of requesting channels (2..8).
- DW, 8: sample width, two's complement.
- ACCW, 28: MAC accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NCH  per-channel request. Level; held until granted.
- x  in  NCH*DW  per-channel sample. Channel c is x[c*DW +: DW].
- gnt  out  NCH  one-hot grant pulse. Combinational.
- flush  in  1  zero all channel histories.
- mac_clr  out  1  clear shared accumulator at next edge.
- mac_en  out  1  accumulate at next edge: acc += mac_x * coef[mac_tap].
- mac_x  out  DW  sample presented to MAC.
- mac_tap  out  4  coefficient index 0..15.
- mac_acc  in  ACCW  registered accumulator value from MAC.
- busy  out  1  high in any state other than IDLE.
- y  out  8  rounded filter output.
- y_ch  out  $clog2(NCH)  channel of y.
- y_valid  out  1  one-cycle pulse, y/y_ch valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all histories 0; rr pointer=NCH-1, so ch0 is highest priority first.
  - y=0, y_ch=0, y_valid=0; tap counter 0.
- States: IDLE, MAC, ROUND, OUT.
- IDLE:
  - If flush=1: all histories cleared at the edge. No grant that cycle; flush has priority over req.
  - Else if any req: grant the first requesting channel searching upward from pointer+1, wrapping.
    - gnt[c]=1 for this cycle only; mac_clr=1.
    - At the edge: hist[c] shifts (hist[c][i] <= hist[c][i+1], hist[c][15] <= x[c]); pointer <= c; state -> MAC.
- MAC (16 cycles, k=0..15):
  - mac_en=1, mac_tap=k, mac_x=hist[c][15-k]. The newest sample pairs with tap 0.
  - After k=15 -> ROUND.
- ROUND:
  - mac_acc is final.
  - At the edge: y <= mac_acc[19:12] + mac_acc[11], 8-bit wrap with no saturation; y_ch <= c.
  - State -> OUT.
- OUT:
  - y_valid=1 (registered) for exactly one cycle.
  - Behaves as IDLE for arbitration, so a new grant may coincide with y_valid. Then the state returns to MAC, else IDLE.
- Latency: grant in cycle G; MAC in G+1..G+16; ROUND in G+17; y_valid in G+18. Sustained throughput is one result per 18 cycles.
- y/y_ch hold their values until the next ROUND.
- flush in MAC/ROUND is ignored (not queued). flush in OUT acts as in IDLE.
- req deasserted without a grant is legal and is simply not served. x is sampled only in the grant cycle.
- Requests arriving during MAC wait. Arbitration is starvation-free: each requester is served within NCH grants.
- mac_clr and mac_en are never high in the same cycle. In IDLE/ROUND/OUT with no grant, both are 0 and mac_x=0, mac_tap=0.
- A reset mid-operation aborts the result: no y_valid, and histories are lost.

Decomposition:
- Shared package lpf_pkg:
  - constants TAPS=16, Y_MSB=19, Y_LSB=12, RND_BIT=11;
  - state enum {IDLE, MAC, ROUND, OUT};
  - the 16 LPF coefficients (0xFFF8, 0xFFF0, 0x0020, 0x0060, 0xFF40, 0xFEC0, 0x0280, 0x0800, mirrored), used by the MAC and the bench model.
- One sub-module: rr_arbiter (NCH-wide round-robin, combinational grant plus pointer-update input).

Test Plan:
- After reset, ch0 sends 0x40 on 16 consecutive requests -> 16th result y=0x47 (acc 0x47400), y_ch=0. y_valid is exactly 18 cycles after the gnt pulse.
- After flush, ch1 sends 0x40 then 7 zeros -> 8th result y=0x20 (tap7 × 2048, acc 0x20000).
- After flush, ch2 sends 0x80 then 5 zeros -> 6th result y=0x0A (−128 × −320 = 0xA000). Checks signed handling.
- All four req high from reset -> grants ch0, ch1, ch2, ch3 at G, G+18, G+36, G+54. y_ch follows in order; histories stay independent.
- reset pulled low at MAC k=7 -> busy=0, y_valid never pulses, y=0. The next request on the same channel computes from a zeroed history.
- flush held high in IDLE with req[0]=1 -> no gnt while flush=1; grant in the first cycle after flush drops.

Source files
------------

// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass FIR MAC scheduler: tap count, output
// slice positions, FSM states and the 16-entry symmetric coefficient set.
package lpf_pkg;

  localparam int unsigned TAPS    = 16;
  localparam int unsigned CW      = 16;
  localparam int unsigned Y_MSB   = 19;
  localparam int unsigned Y_LSB   = 12;
  localparam int unsigned RND_BIT = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Symmetric low-pass coefficients, tap 0 pairs with the newest sample.
  function automatic logic signed [CW-1:0] coef(input logic [3:0] tap);
    case (tap)
      4'd0,  4'd15: coef = 16'shFFF8;
      4'd1,  4'd14: coef = 16'shFFF0;
      4'd2,  4'd13: coef = 16'sh0020;
      4'd3,  4'd12: coef = 16'sh0060;
      4'd4,  4'd11: coef = 16'shFF40;
      4'd5,  4'd10: coef = 16'shFEC0;
      4'd6,  4'd9:  coef = 16'sh0280;
      default:      coef = 16'sh0800;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from
// pointer+1 (wrapping); the pointer moves to the winner when take is high.
//   clk, reset : clock, async active-low reset (pointer -> NCH-1)
//   en         : arbitration allowed this cycle
//   req        : per-channel request
//   take       : accept this cycle's grant and advance the pointer
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted channel
//   gnt_vld    : a grant is being issued
module rr_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NCH-1:0]           req,
  input  logic                     take,
  output logic [NCH-1:0]           gnt,
  output logic [$clog2(NCH)-1:0]   gnt_idx,
  output logic                     gnt_vld
);

  localparam int unsigned PW = $clog2(NCH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] cand;

  // First requester after the pointer wins; the pointer itself is searched last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    if (en) begin
      for (int unsigned i = 1; i <= NCH; i++) begin
        cand = PW'((32'(ptr_q) + i) % NCH);
        if (!gnt_vld && req[cand]) begin
          gnt_vld   = 1'b1;
          gnt_idx   = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  // Reset to NCH-1 so channel 0 is first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= PW'(NCH - 1);
    end else if (take) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/lpf_mac_sched.sv
// Shares one 16-tap FIR MAC between NCH channels: keeps a 16-deep history per
// channel, grants requests round-robin, steps the MAC through 16 taps and
// rounds the accumulator to an 8-bit result tagged with its channel.
//   clk, reset          : clock, async active-low reset
//   req, x              : per-channel request (level) and sample
//   gnt                 : one-hot grant pulse (combinational)
//   flush               : clear all histories (IDLE/OUT only)
//   mac_clr             : clear accumulator at next edge (grant cycle)
//   mac_en/mac_x/mac_tap: accumulate mac_x * coef[mac_tap] at next edge
//   mac_acc             : accumulator value from the MAC
//   busy                : not in IDLE
//   y, y_ch, y_valid    : rounded result, its channel, one-cycle valid
module lpf_mac_sched
  import lpf_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*DW-1:0]      x,
  output logic [NCH-1:0]         gnt,
  input  logic                   flush,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [DW-1:0]          mac_x,
  output logic [3:0]             mac_tap,
  input  logic [ACCW-1:0]        mac_acc,
  output logic                   busy,
  output logic [7:0]             y,
  output logic [$clog2(NCH)-1:0] y_ch,
  output logic                   y_valid
);

  localparam int unsigned PW = $clog2(NCH);

  state_t                   state_q;
  logic [PW-1:0]            ch_q;
  logic [3:0]               tap_q;
  logic [TAPS-1:0][DW-1:0]  hist_q [NCH];
  logic [DW-1:0]            x_ch   [NCH];
  logic                     arb_en;
  logic                     gnt_vld;
  logic [PW-1:0]            gnt_idx;
  logic [7:0]               y_rnd;
  logic                     unused_acc;

  for (genvar c = 0; c < NCH; c++) begin : g_xsplit
    assign x_ch[c] = x[c*DW +: DW];
  end

  // OUT arbitrates like IDLE so back-to-back requests keep an 18-cycle cadence.
  assign arb_en = ((state_q == IDLE) || (state_q == OUT)) && !flush;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req     (req),
    .take    (gnt_vld),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign mac_clr = gnt_vld;
  assign mac_tap = tap_q;

  // Round half up on bit 11; 8-bit wrap, no saturation.
  assign y_rnd      = mac_acc[Y_MSB:Y_LSB] + 8'(mac_acc[RND_BIT]);
  assign unused_acc = ^{mac_acc[ACCW-1:Y_MSB+1], mac_acc[RND_BIT-1:0]};

  // Scheduler FSM; MAC-side outputs are registered one cycle ahead of use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tap_q   <= '0;
      for (int unsigned c = 0; c < NCH; c++) hist_q[c] <= '0;
      mac_en  <= 1'b0;
      mac_x   <= '0;
      busy    <= 1'b0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      mac_en  <= 1'b0;
      mac_x   <= '0;
      y_valid <= 1'b0;
      unique case (state_q)
        IDLE, OUT: begin
          if (flush) begin
            for (int unsigned c = 0; c < NCH; c++) hist_q[c] <= '0;
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (gnt_vld) begin
            // Newest sample enters at index 15 and feeds tap 0 next cycle.
            hist_q[gnt_idx] <= {x_ch[gnt_idx], hist_q[gnt_idx][TAPS-1:1]};
            ch_q    <= gnt_idx;
            tap_q   <= '0;
            mac_en  <= 1'b1;
            mac_x   <= x_ch[gnt_idx];
            state_q <= MAC;
            busy    <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        MAC: begin
          if (tap_q == 4'(TAPS - 1)) begin
            tap_q   <= '0;
            state_q <= ROUND;
          end else begin
            tap_q  <= tap_q + 4'd1;
            mac_en <= 1'b1;
            mac_x  <= hist_q[ch_q][4'(TAPS - 2) - tap_q];
          end
        end
        ROUND: begin
          y       <= y_rnd;
          y_ch    <= ch_q;
          y_valid <= 1'b1;
          state_q <= OUT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpf_mac_sched.sv
// Directed bench for lpf_mac_sched with a behavioural accumulator acting as
// the shared MAC; expected results are hand-computed constants.
module tb_lpf_mac_sched;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int ACCW = 28;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCH-1:0]          req;
  logic [NCH*DW-1:0]       x;
  logic [NCH-1:0]          gnt;
  logic                    flush;
  logic                    mac_clr;
  logic                    mac_en;
  logic [DW-1:0]           mac_x;
  logic [3:0]              mac_tap;
  logic signed [ACCW-1:0]  acc = '0;
  logic                    busy;
  logic [7:0]              y;
  logic [1:0]              y_ch;
  logic                    y_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lpf_mac_sched #(.NCH(NCH), .DW(DW), .ACCW(ACCW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .x       (x),
    .gnt     (gnt),
    .flush   (flush),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .mac_x   (mac_x),
    .mac_tap (mac_tap),
    .mac_acc (acc),
    .busy    (busy),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid)
  );

  // Shared MAC stand-in.
  always @(posedge clk) begin
    if (mac_clr)     acc <= '0;
    else if (mac_en) acc <= acc + 28'($signed(mac_x) * lpf_pkg::coef(mac_tap));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) check("clr_en_excl", 32'(mac_clr & mac_en), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raise req[ch] with sample s, wait for its grant and its result.
  task automatic serve(input int ch, input logic [7:0] s,
                       output logic [7:0] yo, output int yc, output int lat);
    int wn;
    req[ch] = 1'b1;
    x[ch*DW +: DW] = s;
    wn = 0;
    #1;
    while (!gnt[ch] && wn < 60) begin
      @(negedge clk); #1; wn++;
    end
    check("gnt_seen", 32'(gnt[ch]), 32'd1);
    @(negedge clk);
    req[ch] = 1'b0;
    lat = 1;
    #1;
    while (!y_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check("y_valid_seen", 32'(y_valid), 32'd1);
    yo = y;
    yc = int'(y_ch);
  endtask

  logic [7:0] yo;
  int         yc, lat, wn, vcount, dcyc;
  logic [NCH-1:0] gq[$];
  int             gc[$];
  int             yq[$];
  logic [NCH-1:0] drop;

  initial begin
    reset = 1'b0; req = '0; x = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_y",       32'(y),       32'd0);
    check("rst_y_ch",    32'(y_ch),    32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_mac_en",  32'(mac_en),  32'd0);
    check("rst_mac_x",   32'(mac_x),   32'd0);
    check("rst_mac_tap", 32'(mac_tap), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ch0: 16 x 0x40. First result -512 rounds to 0; 16th 0x47400 -> 0x47.
    for (int i = 0; i < 16; i++) begin
      serve(0, 8'h40, yo, yc, lat);
      if (i == 0) check("t1_first_y", 32'(yo), 32'h00);
    end
    check("t1_y",       32'(yo), 32'h47);
    check("t1_y_ch",    32'(yc), 32'd0);
    check("t1_latency", 32'(lat), 32'd18);
    check("t1_busy_out", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_y_hold",    32'(y),    32'h47);

    // Flush, then ch0 zero sample must see an all-zero history.
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    serve(0, 8'h00, yo, yc, lat);
    check("t2_flush_y", 32'(yo), 32'h00);
    // ch1: 0x40 then 7 zeros -> 0x40 on tap 7 (2048) -> 0x20000 -> 0x20.
    serve(1, 8'h40, yo, yc, lat);
    for (int i = 0; i < 7; i++) serve(1, 8'h00, yo, yc, lat);
    check("t2_y",    32'(yo), 32'h20);
    check("t2_y_ch", 32'(yc), 32'd1);

    // ch2: 0x80 then 5 zeros -> -128 * -320 = 0xA000 -> 0x0A.
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    serve(2, 8'h80, yo, yc, lat);
    for (int i = 0; i < 5; i++) serve(2, 8'h00, yo, yc, lat);
    check("t3_y",    32'(yo), 32'h0A);
    check("t3_y_ch", 32'(yc), 32'd2);

    // All four requesting out of reset: grants 0,1,2,3 every 18 cycles.
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    x = {8'h10, 8'h20, 8'h30, 8'h40};
    req = 4'hF;
    reset = 1'b1;
    drop = '0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      #1;
      if (gnt != '0) begin
        gq.push_back(gnt);
        gc.push_back(cyc);
        drop = gnt;
      end
      if (y_valid) yq.push_back(int'(y_ch));
      if (yq.size() == 4) break;
      @(negedge clk);
      req = req & ~drop;
      drop = '0;
    end
    req = '0;
    check("t4_n_grants",  32'(gq.size()), 32'd4);
    check("t4_n_results", 32'(yq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
        check($sformatf("t4_gnt%0d", i), 32'(gq[i]), 32'(1 << i));
        dcyc = gc[i] - gc[0];
        check($sformatf("t4_gap%0d", i), 32'(dcyc), 32'(18 * i));
      end
      if (i < yq.size()) check($sformatf("t4_y_ch%0d", i), 32'(yq[i]), 32'(i));
    end
    @(negedge clk);

    // Reset during MAC k=7 aborts the result and clears histories.
    for (int i = 0; i < 8; i++) serve(0, 8'h40, yo, yc, lat);
    req[0] = 1'b1; x[7:0] = 8'h40;
    wn = 0;
    #1;
    while (!gnt[0] && wn < 60) begin
      @(negedge clk); #1; wn++;
    end
    check("t5_gnt", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    check("t5_tap7", 32'(mac_tap), 32'd7);
    reset = 1'b0;
    #1;
    check("t5_busy",   32'(busy),    32'd0);
    check("t5_y",      32'(y),       32'd0);
    check("t5_mac_en", 32'(mac_en),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (y_valid) vcount++;
    end
    check("t5_no_valid", 32'(vcount), 32'd0);
    serve(0, 8'h40, yo, yc, lat);
    check("t5_zero_hist_y", 32'(yo), 32'h00);
    @(negedge clk);

    // flush held in IDLE blocks the grant; grant follows as soon as it drops.
    flush = 1'b1; req[0] = 1'b1; x[7:0] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_no_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
    end
    flush = 1'b0;
    #1;
    check("t6_gnt_after_flush", 32'(gnt), 32'd1);
    serve(0, 8'h00, yo, yc, lat);
    check("t6_y_ch", 32'(yc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
